// File: rtl/hello_pkg.sv
// Shared definitions for the hello datapath: operation encoding and the op field type.
package hello_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_AND = 2'b10;
    localparam op_t OP_XOR = 2'b11;

endpackage

// File: rtl/hello_alu_comb.sv
// Combinational two-operand ALU: unsigned add/sub with carry/borrow, bitwise AND/XOR.
module hello_alu_comb
    import hello_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // The extra MSB of the widened difference is the borrow when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            OP_AND: result = a & b;
            OP_XOR: result = a ^ b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hello_core.sv
// Registered ALU leaf block: one-cycle latency, one request per cycle, carry and zero flags.
module hello_core
    import hello_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] result_p0;
    logic             carry_p0;
    logic [WIDTH-1:0] c_p1;
    logic             carry_p1;
    logic             zero_p1;
    logic             vld_p1;

    hello_alu_comb #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result_p0),
        .carry  (carry_p0)
    );

    // p0 -> p1: capture result and flags on an accepted request; reset drops any request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_p1     <= '0;
            carry_p1 <= 1'b0;
            zero_p1  <= 1'b1;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                c_p1     <= result_p0;
                carry_p1 <= carry_p0;
                zero_p1  <= (result_p0 == '0);
            end
        end
    end

    assign c         = c_p1;
    assign carry     = carry_p1;
    assign zero      = zero_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_hello_core.sv
// Bench for hello_core: directed plan vectors plus random traffic against an arithmetic reference model.
module tb_hello_core;
    import hello_pkg::*;

    localparam int W = 5;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    op_t          op = OP_ADD;
    logic         in_valid = 1'b0;
    logic [W-1:0] c;
    logic         carry;
    logic         zero;
    logic         out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the outputs should show after the most recent edge.
    int exp_c     = 0;
    int exp_carry = 0;
    int exp_zero  = 1;
    int exp_vld   = 0;

    hello_core #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .in_valid  (in_valid),
        .c         (c),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void ref_alu(input int x, input int y, input int o,
                                    output int r, output int cy);
        case (o)
            0: begin r = (x + y) % MOD;       cy = ((x + y) >= MOD) ? 1 : 0; end
            1: begin r = (x - y + MOD) % MOD; cy = (x < y) ? 1 : 0; end
            2: begin r = x & y;               cy = 0; end
            default: begin r = x ^ y;         cy = 0; end
        endcase
    endfunction

    task automatic step(input int xa, input int xb, input int xop, input bit v, input bit rn);
        int r, cy;
        @(negedge clk);
        a        = W'(xa);
        b        = W'(xb);
        op       = op_t'(xop);
        in_valid = v;
        rst_n    = rn;
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_c = 0; exp_carry = 0; exp_zero = 1; exp_vld = 0;
        end else begin
            exp_vld = v;
            if (v) begin
                ref_alu(xa, xb, xop, r, cy);
                exp_c     = r;
                exp_carry = cy;
                exp_zero  = (r == 0) ? 1 : 0;
            end
        end
        check("c",         int'(c),         exp_c);
        check("carry",     int'(carry),     exp_carry);
        check("zero",      int'(zero),      exp_zero);
        check("out_valid", int'(out_valid), exp_vld);
    endtask

    initial begin
        // Reset for two cycles with a request presented that must be dropped.
        step(3, 4, 0, 1'b1, 1'b0);
        step(3, 4, 0, 1'b1, 1'b0);
        check("rst_c", int'(c), 0);
        check("rst_zero", int'(zero), 1);

        step(5'b00010, 5'b10100, 0, 1'b1, 1'b1);
        check("add_c", int'(c), 5'b10110);
        check("add_vld", int'(out_valid), 1);
        step(5'b00001, 5'b00000, 0, 1'b1, 1'b1);
        check("add0_c", int'(c), 5'b00001);
        step(5'b01111, 5'b11100, 0, 1'b1, 1'b1);
        check("addov_c", int'(c), 5'b01011);
        check("addov_carry", int'(carry), 1);
        step(5'b00101, 5'b00101, 1, 1'b1, 1'b1);
        check("subeq_zero", int'(zero), 1);
        step(5'b00001, 5'b00010, 1, 1'b1, 1'b1);
        check("subb_c", int'(c), 5'b11111);
        check("subb_carry", int'(carry), 1);
        step(5'b10110, 5'b01110, 2, 1'b1, 1'b1);
        check("and_c", int'(c), 5'b00110);
        step(5'b10110, 5'b01110, 3, 1'b1, 1'b1);
        check("xor_c", int'(c), 5'b11000);
        for (int i = 0; i < 3; i++) begin
            step(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                 int'($urandom_range(3)), 1'b0, 1'b1);
            check("hold_c", int'(c), 5'b11000);
        end

        // Reset mid-stream: request coinciding with reset must never appear.
        step(7, 9, 0, 1'b1, 1'b1);
        step(1, 1, 0, 1'b1, 1'b0);
        check("midrst_vld", int'(out_valid), 0);
        step(2, 2, 0, 1'b0, 1'b1);
        check("midrst_after_vld", int'(out_valid), 0);
        check("midrst_after_c", int'(c), 0);

        // Random traffic with occasional idles and resets.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                 int'($urandom_range(3)),
                 ($urandom_range(3) != 0), ($urandom_range(29) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
